mem_port_arbiter: RTL

//   Round-robin arbiter sharing one 32-bit data-memory port among 4 requesters.

---
 rtl/arb_pkg.sv | 24 ++
 rtl/rr_pick4.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the memory-port round-robin arbiter.
//   arb_state_e : arbiter FSM states (idle / transaction in flight)
//   N_REQ       : number of requesters (fixed at 4, matches the 2-bit select)
//   SEL_W       : width of the mux select / winner index
//   TIMEOUT_CYC : BUSY cycles without an ack before a forced release
//   CNT_W       : width of the timeout counter
//   onehot_sel  : converts a winner index into a one-hot requester vector
package arb_pkg;

    localparam int N_REQ       = 4;
    localparam int SEL_W       = 2;
    localparam int TIMEOUT_CYC = 16;
    localparam int CNT_W       = 5;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot_sel(input logic [SEL_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker for four requesters.
// Scans circularly starting at ptr+1 and returns the first set request.
//   req : request vector, bit k = requester k
//   ptr : index of the previous winner (lowest priority this round)
//   any : at least one request is set
//   idx : index of the selected requester (0 when any is low)
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] start_s;
    logic [7:0]       dbl_s;
    logic [3:0]       rot_s;
    logic [SEL_W-1:0] off_s;

    // Rotate the request vector so the highest-priority candidate lands in bit 0.
    assign start_s = ptr + 2'd1;
    assign dbl_s   = {req, req} >> start_s;
    assign rot_s   = dbl_s[3:0];
    assign any     = |req;

    // Priority-encode the rotated vector; the offset is relative to start_s.
    always_comb begin
        off_s = 2'd0;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
    end

    assign idx = any ? (start_s + off_s) : 2'd0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 32-bit data-memory port among 4 requesters.
// Grants one requester at a time, holds the grant through a mem_req/mem_ack
// transaction and returns a one-cycle done pulse to the winner.
// Optional feature macro: ARB_TIMEOUT_EN (forced release after TIMEOUT_CYC
// BUSY cycles without mem_ack_i, flagged by an err_o pulse).
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-low reset
//   req_i     : per-requester request level
//   mem_ack_i : memory completion pulse, sampled only in BUSY
//   gnt_o     : one-hot grant, zero when no transaction is active
//   select_o  : index of the current / last winner (mux select)
//   mem_req_o : transaction valid to memory, high throughout BUSY
//   done_o    : one-hot one-cycle completion pulse to the winner
//   err_o     : one-cycle pulse on timeout release (0 without the macro)
module mem_port_arbiter
    import arb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             mem_ack_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [SEL_W-1:0] select_o,
    output logic             mem_req_o,
    output logic [N_REQ-1:0] done_o,
    output logic             err_o
);

    arb_state_e       state_r, state_n;
    logic [N_REQ-1:0] gnt_r, gnt_n;
    logic [SEL_W-1:0] sel_r, sel_n;
    logic             mem_req_r, mem_req_n;
    logic [N_REQ-1:0] done_r, done_n;
    logic             err_r, err_n;
    logic [SEL_W-1:0] ptr_r, ptr_n;
    logic             any_s;
    logic [SEL_W-1:0] win_s;
`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_r, cnt_n;
`endif

    rr_pick4 u_pick (
        .req (req_i),
        .ptr (ptr_r),
        .any (any_s),
        .idx (win_s)
    );

    // Next-state and next-output logic; pulses default low, grant state holds.
    always_comb begin
        state_n   = state_r;
        gnt_n     = gnt_r;
        sel_n     = sel_r;
        mem_req_n = mem_req_r;
        done_n    = '0;
        err_n     = 1'b0;
        ptr_n     = ptr_r;
`ifdef ARB_TIMEOUT_EN
        cnt_n     = cnt_r;
`endif
        case (state_r)
            ARB_IDLE: begin
                if (any_s) begin
                    gnt_n     = onehot_sel(win_s);
                    sel_n     = win_s;
                    mem_req_n = 1'b1;
                    state_n   = ARB_BUSY;
`ifdef ARB_TIMEOUT_EN
                    cnt_n     = '0;
`endif
                end else begin
                    gnt_n     = '0;
                    mem_req_n = 1'b0;
                end
            end
            ARB_BUSY: begin
                // Request changes are ignored here; only ack (or timeout) ends it.
                if (mem_ack_i) begin
                    done_n    = gnt_r;
                    gnt_n     = '0;
                    mem_req_n = 1'b0;
                    ptr_n     = sel_r;
                    state_n   = ARB_IDLE;
                end else begin
`ifdef ARB_TIMEOUT_EN
                    // cnt_r counts completed ack-less BUSY cycles; the
                    // TIMEOUT_CYC-th one releases the port.
                    if (cnt_r == CNT_W'(TIMEOUT_CYC - 1)) begin
                        done_n    = gnt_r;
                        err_n     = 1'b1;
                        gnt_n     = '0;
                        mem_req_n = 1'b0;
                        ptr_n     = sel_r;
                        state_n   = ARB_IDLE;
                    end else begin
                        cnt_n = cnt_r + CNT_W'(1);
                    end
`else
                    state_n = ARB_BUSY;
`endif
                end
            end
            default: begin
                state_n   = ARB_IDLE;
                gnt_n     = '0;
                mem_req_n = 1'b0;
            end
        endcase
    end

    // State, pointer and registered outputs; ptr resets to 3 so requester 0 wins first.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r   <= ARB_IDLE;
            gnt_r     <= '0;
            sel_r     <= 2'd0;
            mem_req_r <= 1'b0;
            done_r    <= '0;
            err_r     <= 1'b0;
            ptr_r     <= 2'd3;
        end else begin
            state_r   <= state_n;
            gnt_r     <= gnt_n;
            sel_r     <= sel_n;
            mem_req_r <= mem_req_n;
            done_r    <= done_n;
            err_r     <= err_n;
            ptr_r     <= ptr_n;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Timeout counter register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_n;
        end
    end
`endif

    assign gnt_o     = gnt_r;
    assign select_o  = sel_r;
    assign mem_req_o = mem_req_r;
    assign done_o    = done_r;
    assign err_o     = err_r;

endmodule
